cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter_pkg.sv | 26 ++
 rtl/cache_mem_arbiter_rr_arb2.sv | 28 ++
 rtl/cache_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings for the cache-to-bridge memory arbiter.
package cache_mem_arbiter_pkg;

    localparam int LINE_OFS = 4;

    localparam logic [2:0] TYPE_LINE = 3'b100;
    localparam logic [2:0] TYPE_WORD = 3'b010;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_RET
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_WAIT
    } wr_state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } owner_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is favoured after reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // set when req[1] won the most recent grant
    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else if (en && (|gnt)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache read bursts and dcache write-backs onto the bridge.
module cache_mem_arbiter #(
    parameter int LINE_OFS = cache_mem_arbiter_pkg::LINE_OFS
) (
    input  logic         clk,
    input  logic         resetn,

    input  logic         ic_rd_req,
    input  logic [2:0]   ic_rd_type,
    input  logic [31:0]  ic_rd_addr,
    output logic         ic_rd_rdy,
    output logic         ic_ret_valid,
    output logic         ic_ret_last,
    output logic [31:0]  ic_ret_data,

    input  logic         dc_rd_req,
    input  logic [2:0]   dc_rd_type,
    input  logic [31:0]  dc_rd_addr,
    output logic         dc_rd_rdy,
    output logic         dc_ret_valid,
    output logic         dc_ret_last,
    output logic [31:0]  dc_ret_data,

    input  logic         dc_wr_req,
    input  logic [2:0]   dc_wr_type,
    input  logic [31:0]  dc_wr_addr,
    input  logic [3:0]   dc_wr_wstrb,
    input  logic [127:0] dc_wr_data,
    output logic         dc_wr_rdy,

    output logic         mem_rd_req,
    output logic [2:0]   mem_rd_type,
    output logic [31:0]  mem_rd_addr,
    input  logic         mem_rd_rdy,
    input  logic         mem_ret_valid,
    input  logic         mem_ret_last,
    input  logic [31:0]  mem_ret_data,

    output logic         mem_wr_req,
    output logic [2:0]   mem_wr_type,
    output logic [31:0]  mem_wr_addr,
    output logic [3:0]   mem_wr_wstrb,
    output logic [127:0] mem_wr_data,
    input  logic         mem_wr_rdy,
    input  logic         mem_wr_done
);

    import cache_mem_arbiter_pkg::*;

    rd_state_t    r_state;
    rd_state_t    r_next;
    wr_state_t    w_state;
    wr_state_t    w_next;

    owner_t       owner_q;
    logic [2:0]   r_type_q;
    logic [31:0]  r_addr_q;

    logic [2:0]   w_type_q;
    logic [31:0]  w_addr_q;
    logic [3:0]   w_wstrb_q;
    logic [127:0] w_data_q;

    logic         w_busy;
    logic         ic_haz;
    logic         dc_haz;
    logic [1:0]   elig;
    logic [1:0]   gnt;
    logic         grant_en;
    logic         w_latch;

    // a read to the line being written back waits until the write completes
    assign w_busy = (w_state != W_IDLE);
    assign ic_haz = w_busy &&
        (ic_rd_addr[31:LINE_OFS] == w_addr_q[31:LINE_OFS]);
    assign dc_haz = w_busy &&
        (dc_rd_addr[31:LINE_OFS] == w_addr_q[31:LINE_OFS]);

    assign elig = {dc_rd_req && !dc_haz, ic_rd_req && !ic_haz};

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .resetn (resetn),
        .req    (elig),
        .en     (grant_en),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next   = r_state;
        grant_en = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (|gnt) begin
                    r_next   = R_REQ;
                    grant_en = 1'b1;
                end
            end
            R_REQ: begin
                if (mem_rd_rdy) begin
                    r_next = R_RET;
                end
            end
            R_RET: begin
                if (mem_ret_valid && mem_ret_last) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q  <= OWN_IC;
            r_type_q <= '0;
            r_addr_q <= '0;
        end else if (grant_en) begin
            owner_q  <= gnt[1] ? OWN_DC : OWN_IC;
            r_type_q <= gnt[1] ? dc_rd_type : ic_rd_type;
            r_addr_q <= gnt[1] ? dc_rd_addr : ic_rd_addr;
        end
    end

    logic in_req;
    logic in_ret;
    logic own_ic;
    logic own_dc;

    assign in_req = (r_state == R_REQ);
    assign in_ret = (r_state == R_RET);
    assign own_ic = (owner_q == OWN_IC);
    assign own_dc = (owner_q == OWN_DC);

    assign mem_rd_req  = in_req;
    assign mem_rd_type = r_type_q;
    assign mem_rd_addr = r_addr_q;

    assign ic_rd_rdy = in_req && own_ic && mem_rd_rdy;
    assign dc_rd_rdy = in_req && own_dc && mem_rd_rdy;

    // returns outside a burst (e.g. stragglers after reset) are dropped
    assign ic_ret_valid = in_ret && own_ic && mem_ret_valid;
    assign ic_ret_last  = in_ret && own_ic && mem_ret_last;
    assign ic_ret_data  = (in_ret && own_ic) ? mem_ret_data : '0;
    assign dc_ret_valid = in_ret && own_dc && mem_ret_valid;
    assign dc_ret_last  = in_ret && own_dc && mem_ret_last;
    assign dc_ret_data  = (in_ret && own_dc) ? mem_ret_data : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next  = w_state;
        w_latch = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (dc_wr_req) begin
                    w_next  = W_SEND;
                    w_latch = 1'b1;
                end
            end
            W_SEND: begin
                if (mem_wr_rdy) begin
                    w_next = W_WAIT;
                end
            end
            W_WAIT: begin
                if (mem_wr_done) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_type_q  <= '0;
            w_addr_q  <= '0;
            w_wstrb_q <= '0;
            w_data_q  <= '0;
        end else if (w_latch) begin
            w_type_q  <= dc_wr_type;
            w_addr_q  <= dc_wr_addr;
            w_wstrb_q <= dc_wr_wstrb;
            w_data_q  <= dc_wr_data;
        end
    end

    assign mem_wr_req   = (w_state == W_SEND);
    assign mem_wr_type  = w_type_q;
    assign mem_wr_addr  = w_addr_q;
    assign mem_wr_wstrb = w_wstrb_q;
    assign mem_wr_data  = w_data_q;

    // held low while reset is asserted so every output reads zero
    assign dc_wr_rdy = resetn && (w_state == W_IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;

    logic         ic_rd_req = 1'b0;
    logic [2:0]   ic_rd_type = '0;
    logic [31:0]  ic_rd_addr = '0;
    logic         ic_rd_rdy;
    logic         ic_ret_valid;
    logic         ic_ret_last;
    logic [31:0]  ic_ret_data;

    logic         dc_rd_req = 1'b0;
    logic [2:0]   dc_rd_type = '0;
    logic [31:0]  dc_rd_addr = '0;
    logic         dc_rd_rdy;
    logic         dc_ret_valid;
    logic         dc_ret_last;
    logic [31:0]  dc_ret_data;

    logic         dc_wr_req = 1'b0;
    logic [2:0]   dc_wr_type = '0;
    logic [31:0]  dc_wr_addr = '0;
    logic [3:0]   dc_wr_wstrb = '0;
    logic [127:0] dc_wr_data = '0;
    logic         dc_wr_rdy;

    logic         mem_rd_req;
    logic [2:0]   mem_rd_type;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_rdy = 1'b0;
    logic         mem_ret_valid = 1'b0;
    logic         mem_ret_last = 1'b0;
    logic [31:0]  mem_ret_data = '0;

    logic         mem_wr_req;
    logic [2:0]   mem_wr_type;
    logic [31:0]  mem_wr_addr;
    logic [3:0]   mem_wr_wstrb;
    logic [127:0] mem_wr_data;
    logic         mem_wr_rdy = 1'b0;
    logic         mem_wr_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.LINE_OFS(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ic_rd_req    (ic_rd_req),
        .ic_rd_type   (ic_rd_type),
        .ic_rd_addr   (ic_rd_addr),
        .ic_rd_rdy    (ic_rd_rdy),
        .ic_ret_valid (ic_ret_valid),
        .ic_ret_last  (ic_ret_last),
        .ic_ret_data  (ic_ret_data),
        .dc_rd_req    (dc_rd_req),
        .dc_rd_type   (dc_rd_type),
        .dc_rd_addr   (dc_rd_addr),
        .dc_rd_rdy    (dc_rd_rdy),
        .dc_ret_valid (dc_ret_valid),
        .dc_ret_last  (dc_ret_last),
        .dc_ret_data  (dc_ret_data),
        .dc_wr_req    (dc_wr_req),
        .dc_wr_type   (dc_wr_type),
        .dc_wr_addr   (dc_wr_addr),
        .dc_wr_wstrb  (dc_wr_wstrb),
        .dc_wr_data   (dc_wr_data),
        .dc_wr_rdy    (dc_wr_rdy),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_type  (mem_rd_type),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_rdy   (mem_rd_rdy),
        .mem_ret_valid(mem_ret_valid),
        .mem_ret_last (mem_ret_last),
        .mem_ret_data (mem_ret_data),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_type  (mem_wr_type),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_wstrb (mem_wr_wstrb),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_rdy   (mem_wr_rdy),
        .mem_wr_done  (mem_wr_done)
    );

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
        dc_wr_req = 1'b0;
        mem_rd_rdy = 1'b0;
        mem_ret_valid = 1'b0;
        mem_ret_last = 1'b0;
        mem_wr_rdy = 1'b0;
        mem_wr_done = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    // serve one 4-beat read burst for the given owner at address a
    task automatic serve_read(input bit dc,
                              input logic [31:0] a,
                              input int stall);
        int n = 0;
        while (!mem_rd_req && n < 20) begin
            step();
            n++;
        end
        chk("rd_req_seen", {127'd0, mem_rd_req}, 128'd1);
        chk("rd_addr", {96'd0, mem_rd_addr}, {96'd0, a});
        for (int i = 0; i < stall; i++) begin
            chk("stall_req", {127'd0, mem_rd_req}, 128'd1);
            chk("stall_addr", {96'd0, mem_rd_addr}, {96'd0, a});
            chk("stall_rdy", {127'd0, dc ? dc_rd_rdy : ic_rd_rdy}, 128'd0);
            step();
        end
        mem_rd_rdy = 1'b1;
        #1;
        chk("own_rdy", {127'd0, dc ? dc_rd_rdy : ic_rd_rdy}, 128'd1);
        chk("oth_rdy", {127'd0, dc ? ic_rd_rdy : dc_rd_rdy}, 128'd0);
        step();
        mem_rd_rdy = 1'b0;
        if (dc) dc_rd_req = 1'b0;
        else    ic_rd_req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_ret_valid = 1'b1;
            mem_ret_last  = (b == 3);
            mem_ret_data  = a + 32'h100 * b + 32'h5;
            #1;
            chk("ret_valid", {127'd0, dc ? dc_ret_valid : ic_ret_valid},
                128'd1);
            chk("ret_last", {127'd0, dc ? dc_ret_last : ic_ret_last},
                {127'd0, b == 3});
            chk("ret_data", {96'd0, dc ? dc_ret_data : ic_ret_data},
                {96'd0, a + 32'h100 * b + 32'h5});
            chk("oth_valid", {127'd0, dc ? ic_ret_valid : dc_ret_valid},
                128'd0);
            step();
        end
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] wdat;
        logic [31:0]  wa;
        bit           exp_dc;

        // reset state
        step();
        #1;
        chk("rst_mem_rd_req", {127'd0, mem_rd_req}, 128'd0);
        chk("rst_mem_wr_req", {127'd0, mem_wr_req}, 128'd0);
        chk("rst_dc_wr_rdy", {127'd0, dc_wr_rdy}, 128'd0);
        chk("rst_ic_rdy", {127'd0, ic_rd_rdy}, 128'd0);
        resetn = 1'b1;
        step();
        chk("post_rst_wr_rdy", {127'd0, dc_wr_rdy}, 128'd1);
        chk("post_rst_rd_addr", {96'd0, mem_rd_addr}, 128'd0);

        // basic icache burst, one-cycle request latency
        ic_rd_req  = 1'b1;
        ic_rd_type = 3'b100;
        ic_rd_addr = 32'h1C00_0000;
        step();
        chk("ic_lat_req", {127'd0, mem_rd_req}, 128'd1);
        chk("ic_lat_type", {125'd0, mem_rd_type}, {125'd0, 3'b100});
        serve_read(1'b0, 32'h1C00_0000, 0);

        // bridge holds off acceptance for five cycles
        ic_rd_req  = 1'b1;
        ic_rd_addr = 32'h1C00_0040;
        serve_read(1'b0, 32'h1C00_0040, 5);

        // round-robin from a fresh reset: IC, DC, IC, DC
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            ic_rd_req  = 1'b1;
            ic_rd_addr = 32'h0000_0100;
            dc_rd_req  = 1'b1;
            dc_rd_type = 3'b010;
            dc_rd_addr = 32'h0000_0200;
            exp_dc = (r % 2) == 1;
            serve_read(exp_dc, exp_dc ? 32'h0000_0200 : 32'h0000_0100, 0);
            ic_rd_req = 1'b0;
            dc_rd_req = 1'b0;
            step();
        end

        // read-after-write hazard on the same line
        dc_wr_req   = 1'b1;
        dc_wr_type  = 3'b100;
        dc_wr_addr  = 32'h0000_1230;
        dc_wr_wstrb = 4'hF;
        dc_wr_data  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        step();
        dc_wr_req  = 1'b0;
        mem_wr_rdy = 1'b1;
        step();
        mem_wr_rdy = 1'b0;
        chk("haz_wr_rdy_busy", {127'd0, dc_wr_rdy}, 128'd0);
        dc_rd_req  = 1'b1;
        dc_rd_addr = 32'h0000_1234;
        ic_rd_req  = 1'b1;
        ic_rd_addr = 32'h0000_2000;
        serve_read(1'b0, 32'h0000_2000, 0);
        for (int i = 0; i < 3; i++) begin
            chk("haz_blocked", {127'd0, mem_rd_req}, 128'd0);
            step();
        end
        mem_wr_done = 1'b1;
        step();
        mem_wr_done = 1'b0;
        chk("haz_done_cyc", {127'd0, mem_rd_req}, 128'd0);
        chk("haz_wr_idle", {127'd0, dc_wr_rdy}, 128'd1);
        step();
        chk("haz_released", {127'd0, mem_rd_req}, 128'd1);
        serve_read(1'b1, 32'h0000_1234, 0);

        // write in flight alongside a read burst
        wdat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        wa   = 32'h0000_3000;
        dc_wr_req   = 1'b1;
        dc_wr_type  = 3'b100;
        dc_wr_addr  = wa;
        dc_wr_wstrb = 4'hA;
        dc_wr_data  = wdat;
        ic_rd_req   = 1'b1;
        ic_rd_addr  = 32'h0000_4000;
        step();
        dc_wr_req  = 1'b0;
        dc_wr_data = '0;
        chk("wr_req", {127'd0, mem_wr_req}, 128'd1);
        chk("wr_addr", {96'd0, mem_wr_addr}, {96'd0, wa});
        chk("wr_wstrb", {124'd0, mem_wr_wstrb}, 128'hA);
        mem_wr_done = 1'b1;
        step();
        mem_wr_done = 1'b0;
        chk("wr_done_ignored", {127'd0, mem_wr_req}, 128'd1);
        serve_read(1'b0, 32'h0000_4000, 0);
        chk("wr_data", mem_wr_data, wdat);
        mem_wr_rdy = 1'b1;
        step();
        mem_wr_rdy = 1'b0;
        chk("wr_accepted", {127'd0, mem_wr_req}, 128'd0);
        mem_wr_done = 1'b1;
        step();
        mem_wr_done = 1'b0;
        chk("wr_complete", {127'd0, dc_wr_rdy}, 128'd1);

        // reset in the middle of a dcache burst
        dc_rd_req  = 1'b1;
        dc_rd_addr = 32'h0000_5000;
        step();
        chk("mid_rst_req", {127'd0, mem_rd_req}, 128'd1);
        mem_rd_rdy = 1'b1;
        step();
        mem_rd_rdy = 1'b0;
        dc_rd_req  = 1'b0;
        mem_ret_valid = 1'b1;
        mem_ret_data  = 32'hAAAA_0001;
        step();
        mem_ret_data = 32'hAAAA_0002;
        #1;
        chk("beat2_valid", {127'd0, dc_ret_valid}, 128'd1);
        resetn = 1'b0;
        #1;
        chk("rst_dc_valid", {127'd0, dc_ret_valid}, 128'd0);
        chk("rst_dc_data", {96'd0, dc_ret_data}, 128'd0);
        chk("rst_rd_req", {127'd0, mem_rd_req}, 128'd0);
        chk("rst_rd_addr", {96'd0, mem_rd_addr}, 128'd0);
        chk("rst_wr_data", mem_wr_data, 128'd0);
        chk("rst_wr_rdy", {127'd0, dc_wr_rdy}, 128'd0);
        step();
        resetn = 1'b1;
        step();
        chk("stray_dc", {127'd0, dc_ret_valid}, 128'd0);
        chk("stray_ic", {127'd0, ic_ret_valid}, 128'd0);
        chk("stray_wr_rdy", {127'd0, dc_wr_rdy}, 128'd1);
        mem_ret_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
